// File: rtl/falling_sand_engine.sv
// Falling-sand cell-update engine: one bottom-up pass over the game RAM per start pulse,
// moving sand cells down or diagonally down one row, with single-cell paint writes between passes.
module falling_sand_engine #(
  parameter int COLUMNS    = 640,
  parameter int ROWS       = 480,
  parameter int CELL_WIDTH = 2,
  parameter int ADDR_WIDTH = $clog2(COLUMNS*ROWS),
  parameter int X_WIDTH    = $clog2(COLUMNS),
  parameter int Y_WIDTH    = $clog2(ROWS)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] moves_o,
  input  logic                  paint_valid_i,
  output logic                  paint_ready_o,
  input  logic [X_WIDTH-1:0]    paint_x_i,
  input  logic [Y_WIDTH-1:0]    paint_y_i,
  input  logic [CELL_WIDTH-1:0] paint_data_i,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
  input  logic [CELL_WIDTH-1:0] mem_rd_data_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr_o,
  output logic [CELL_WIDTH-1:0] mem_wr_data_o
);

  typedef enum logic [3:0] {
    IDLE, FETCH_SRC, CHECK_SRC, FETCH_DN, CHECK_DN, FETCH_D1, CHECK_D1,
    FETCH_D2, CHECK_D2, MOVE_DST, MOVE_SRC, ADVANCE, DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ROW_STEP   = ADDR_WIDTH'(COLUMNS);
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'((ROWS-2)*COLUMNS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(COLUMNS-1);
  // End of row y back to the start of row y-1.
  localparam logic [ADDR_WIDTH-1:0] WRAP_STEP  = ADDR_WIDTH'(2*COLUMNS-1);
  localparam logic [X_WIDTH-1:0]    X_LAST     = X_WIDTH'(COLUMNS-1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A      = ADDR_WIDTH'(1);

  state_t                  state, state_next;
  logic [X_WIDTH-1:0]      x;
  logic [ADDR_WIDTH-1:0]   src_addr;
  logic [ADDR_WIDTH-1:0]   dst_addr;
  logic [CELL_WIDTH-1:0]   src_code;
  logic [ADDR_WIDTH-1:0]   move_count;
  logic [ADDR_WIDTH-1:0]   moves_q;
  logic                    dir;

  logic [ADDR_WIDTH-1:0]   down_addr, left_addr, right_addr, d1_addr, d2_addr, check_addr;
  logic                    has_left, has_right, d1_ok, d2_ok;
  logic                    rd_empty, rd_sand, last_cell;
  logic                    paint_in_range;
  logic [ADDR_WIDTH-1:0]   paint_addr;

  assign down_addr  = src_addr + ROW_STEP;
  assign left_addr  = src_addr + ROW_STEP - ONE_A;
  assign right_addr = src_addr + ROW_STEP + ONE_A;
  assign has_left   = (x != '0);
  assign has_right  = (x != X_LAST);

  // dir swaps which diagonal is tried first so drift alternates frame to frame.
  assign d1_addr = dir ? right_addr : left_addr;
  assign d2_addr = dir ? left_addr  : right_addr;
  assign d1_ok   = dir ? has_right  : has_left;
  assign d2_ok   = dir ? has_left   : has_right;

  assign rd_empty  = (mem_rd_data_i == '0);
  assign rd_sand   = !rd_empty && (mem_rd_data_i != CELL_WIDTH'(1));
  assign last_cell = (src_addr == LAST_ADDR);

  assign paint_in_range = (32'(paint_x_i) < COLUMNS) && (32'(paint_y_i) < ROWS);
  assign paint_addr     = ADDR_WIDTH'(paint_y_i) * ROW_STEP + ADDR_WIDTH'(paint_x_i);

  assign check_addr = (state == CHECK_DN) ? down_addr :
                      (state == CHECK_D1) ? d1_addr   : d2_addr;

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start_i) state_next = FETCH_SRC;
      FETCH_SRC: state_next = CHECK_SRC;
      CHECK_SRC: state_next = rd_sand ? FETCH_DN : ADVANCE;
      FETCH_DN:  state_next = CHECK_DN;
      CHECK_DN: begin
        if (rd_empty)   state_next = MOVE_DST;
        else if (d1_ok) state_next = FETCH_D1;
        else if (d2_ok) state_next = FETCH_D2;
        else            state_next = ADVANCE;
      end
      FETCH_D1:  state_next = CHECK_D1;
      CHECK_D1: begin
        if (rd_empty)   state_next = MOVE_DST;
        else if (d2_ok) state_next = FETCH_D2;
        else            state_next = ADVANCE;
      end
      FETCH_D2:  state_next = CHECK_D2;
      CHECK_D2:  state_next = rd_empty ? MOVE_DST : ADVANCE;
      MOVE_DST:  state_next = MOVE_SRC;
      MOVE_SRC:  state_next = ADVANCE;
      ADVANCE:   state_next = last_cell ? DONE : FETCH_SRC;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_rd_addr_o = '0;
    case (state)
      FETCH_SRC: mem_rd_addr_o = src_addr;
      FETCH_DN:  mem_rd_addr_o = down_addr;
      FETCH_D1:  mem_rd_addr_o = d1_addr;
      FETCH_D2:  mem_rd_addr_o = d2_addr;
      default:   mem_rd_addr_o = '0;
    endcase
  end

  // Write port is decoded from registered state, so an async reset drops it at once.
  always_comb begin
    mem_we_o      = 1'b0;
    mem_wr_addr_o = '0;
    mem_wr_data_o = '0;
    case (state)
      MOVE_DST: begin
        mem_we_o      = 1'b1;
        mem_wr_addr_o = dst_addr;
        mem_wr_data_o = src_code;
      end
      MOVE_SRC: begin
        mem_we_o      = 1'b1;
        mem_wr_addr_o = src_addr;
      end
      IDLE: begin
        if (paint_valid_i && paint_in_range) begin
          mem_we_o      = 1'b1;
          mem_wr_addr_o = paint_addr;
          mem_wr_data_o = paint_data_i;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state      <= IDLE;
      x          <= '0;
      src_addr   <= '0;
      dst_addr   <= '0;
      src_code   <= '0;
      move_count <= '0;
      moves_q    <= '0;
      dir        <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start_i) begin
            x          <= '0;
            src_addr   <= FIRST_ADDR;
            move_count <= '0;
          end
        end
        CHECK_SRC: src_code <= mem_rd_data_i;
        CHECK_DN, CHECK_D1, CHECK_D2: begin
          if (rd_empty) dst_addr <= check_addr;
        end
        MOVE_SRC: move_count <= move_count + ONE_A;
        ADVANCE: begin
          if (last_cell) begin
            moves_q <= move_count;
          end else if (x == X_LAST) begin
            x        <= '0;
            src_addr <= src_addr - WRAP_STEP;
          end else begin
            x        <= x + X_WIDTH'(1);
            src_addr <= src_addr + ONE_A;
          end
        end
        DONE: dir <= ~dir;
        default: ;
      endcase
    end
  end

  assign busy_o        = (state != IDLE) && (state != DONE);
  assign done_o        = (state == DONE);
  assign moves_o       = moves_q;
  assign paint_ready_o = (state == IDLE);

endmodule

// File: tb/tb_falling_sand_engine.sv
// Directed bench for falling_sand_engine on a 4x4 grid with a synchronous-read RAM model;
// expected grid contents, move counts and pass lengths are hand-computed.
module tb_falling_sand_engine;

  localparam int C  = 4;
  localparam int R  = 4;
  localparam int CW = 2;
  localparam int AW = 4;
  localparam int XW = 3;
  localparam int YW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic [AW-1:0] moves;
  logic          paint_valid = 1'b0;
  logic          paint_ready;
  logic [XW-1:0] paint_x = '0;
  logic [YW-1:0] paint_y = '0;
  logic [CW-1:0] paint_data = '0;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [CW-1:0] rd_data = '0;
  logic [CW-1:0] wr_data;
  logic          we;

  logic [CW-1:0] mem [C*R];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  falling_sand_engine #(
    .COLUMNS(C), .ROWS(R), .CELL_WIDTH(CW), .ADDR_WIDTH(AW), .X_WIDTH(XW), .Y_WIDTH(YW)
  ) dut (
    .clk_i(clk), .reset_i(reset_n), .start_i(start), .busy_o(busy), .done_o(done),
    .moves_o(moves), .paint_valid_i(paint_valid), .paint_ready_o(paint_ready),
    .paint_x_i(paint_x), .paint_y_i(paint_y), .paint_data_i(paint_data),
    .mem_rd_addr_o(rd_addr), .mem_rd_data_i(rd_data), .mem_we_o(we),
    .mem_wr_addr_o(wr_addr), .mem_wr_data_o(wr_data)
  );

  // Game RAM model: synchronous read, registered write; contents set only through paint.
  always @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic paint(input int px, input int py, input int pd);
    @(negedge clk);
    paint_valid = 1'b1;
    paint_x     = XW'(px);
    paint_y     = YW'(py);
    paint_data  = CW'(pd);
    @(negedge clk);
    paint_valid = 1'b0;
  endtask

  task automatic clear_grid();
    for (int yy = 0; yy < R; yy++)
      for (int xx = 0; xx < C; xx++)
        paint(xx, yy, 0);
  endtask

  // Called at the negedge right after start was dropped (DUT in FETCH_SRC).
  task automatic wait_pass(output int busy_cycles, output int mv, output int writes, output int dones);
    int n;
    n = 0; busy_cycles = 0; writes = 0; dones = 0; mv = -1;
    while (!done && n < 300) begin
      if (busy) busy_cycles++;
      if (we) writes++;
      @(negedge clk);
      n++;
    end
    if (!done) begin
      check("pass_timeout", 0, 1);
    end else begin
      dones = 1;
      mv = int'(moves);
      check("busy_low_at_done", int'(busy), 0);
      @(negedge clk);
      if (done) dones++;
    end
  endtask

  task automatic run_pass(output int busy_cycles, output int mv, output int writes, output int dones);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_pass(busy_cycles, mv, writes, dones);
  endtask

  initial begin
    int bc, mv, wr, dn, n;

    // Reset state, paint_ready included while reset is held.
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_we", int'(we), 0);
    check("rst_moves", int'(moves), 0);
    check("rst_ready", int'(paint_ready), 1);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_wr_data", int'(wr_data), 0);
    reset_n = 1'b1;

    // Straight fall of a single grain down column 1.
    clear_grid();
    paint(1, 0, 2);
    run_pass(bc, mv, wr, dn);
    check("fall1_dst", int'(mem[5]), 2);
    check("fall1_src", int'(mem[1]), 0);
    check("fall1_moves", mv, 1);
    check("fall1_done_once", dn, 1);
    check("fall1_cycles", bc, 11*3 + 7);
    check("fall1_writes", wr, 2);
    run_pass(bc, mv, wr, dn);
    check("fall2_moves", mv, 1);
    check("fall2_dst", int'(mem[9]), 2);
    run_pass(bc, mv, wr, dn);
    check("fall3_dst", int'(mem[13]), 2);
    check("fall3_src", int'(mem[9]), 0);
    run_pass(bc, mv, wr, dn);
    check("fall4_moves", mv, 0);
    check("fall4_cycles", bc, 12*3);
    check("fall4_rest", int'(mem[13]), 2);

    // dir=0 (four toggles): blocked by wall, slides below-left.
    clear_grid();
    paint(1, 2, 2);
    paint(1, 3, 1);
    run_pass(bc, mv, wr, dn);
    check("diag_l_dst", int'(mem[12]), 2);
    check("diag_l_src", int'(mem[9]), 0);
    check("diag_l_moves", mv, 1);
    check("diag_l_cycles", bc, 11*3 + 9);

    // After reset dir=0 again; second pass uses dir=1 and slides below-right.
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    clear_grid();
    paint(1, 2, 2);
    paint(1, 3, 1);
    run_pass(bc, mv, wr, dn);
    check("diag_r_first_l", int'(mem[12]), 2);
    paint(0, 3, 0);
    paint(1, 2, 2);
    run_pass(bc, mv, wr, dn);
    check("diag_r_dst", int'(mem[14]), 2);
    check("diag_r_src", int'(mem[9]), 0);
    check("diag_r_left_empty", int'(mem[12]), 0);
    check("diag_r_moves", mv, 1);

    // dir=0 at left edge: left skipped, right is wall, no move.
    clear_grid();
    paint(0, 2, 2);
    paint(0, 3, 2);
    paint(1, 3, 1);
    run_pass(bc, mv, wr, dn);
    check("edge_moves", mv, 0);
    check("edge_writes", wr, 0);
    check("edge_cycles", bc, 11*3 + 7);
    check("edge_src_kept", int'(mem[8]), 2);

    // Paint together with start: write this cycle, scan follows.
    clear_grid();
    @(negedge clk);
    paint_valid = 1'b1; paint_x = 3'd2; paint_y = 2'd0; paint_data = 2'd3;
    start = 1'b1;
    #1;
    check("paint_start_we", int'(we), 1);
    check("paint_start_addr", int'(wr_addr), 2);
    check("paint_start_data", int'(wr_data), 3);
    @(negedge clk);
    paint_valid = 1'b0; start = 1'b0;
    check("paint_start_busy", int'(busy), 1);
    wait_pass(bc, mv, wr, dn);
    check("paint_fall_dst", int'(mem[6]), 3);
    check("paint_fall_src", int'(mem[2]), 0);
    check("paint_fall_moves", mv, 1);

    // Out-of-range paint completes its handshake without a write.
    @(negedge clk);
    paint_valid = 1'b1; paint_x = 3'd5; paint_y = 2'd0; paint_data = 2'd3;
    #1;
    check("oor_ready", int'(paint_ready), 1);
    check("oor_we", int'(we), 0);
    @(negedge clk);
    paint_valid = 1'b0;
    check("oor_no_write", int'(mem[5]), 0);

    // Reset during MOVE_DST aborts the write immediately.
    clear_grid();
    paint(0, 2, 2);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!we && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("mid_reach_move", int'(we), 1);
    check("mid_dst_addr", int'(wr_addr), 12);
    reset_n = 1'b0;
    #1;
    check("mid_we_low", int'(we), 0);
    check("mid_busy_low", int'(busy), 0);
    check("mid_idle", int'(paint_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_no_dst_write", int'(mem[12]), 0);
    check("mid_src_kept", int'(mem[8]), 2);
    run_pass(bc, mv, wr, dn);
    check("post_rst_moves", mv, 1);
    check("post_rst_cycles", bc, 11*3 + 7);
    check("post_rst_dst", int'(mem[12]), 2);
    check("post_rst_src", int'(mem[8]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
